// File: rtl/router_pkg.sv
// Shared router types: flit layout plus the output-unit FSM states and error bit indices.
package router_pkg;

    localparam int unsigned FLIT_SIZE = 16;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2,
        RSVD_FLIT = 2'd3
    } FLIT_TYPE_t;

    // MSB is the valid bit, followed by the flit type.
    typedef struct packed {
        logic                   valid;
        FLIT_TYPE_t             flit_type;
        logic [FLIT_SIZE-4:0]   payload;
    } FLIT_t;

    typedef enum logic [2:0] {
        OU_IDLE,
        OU_REQ,
        OU_RETRY,
        OU_SEND,
        OU_DONE
    } OU_STATE_t;

    localparam int unsigned OU_ACK_TIMEOUT  = 15;
    localparam int unsigned OU_ERR_TIMEOUT  = 0;
    localparam int unsigned OU_ERR_OVERFLOW = 1;

endpackage

// File: rtl/sfifo.sv
// Synchronous show-ahead FIFO with 2**ADDR_WIDTH entries; rdata is the current head.
module sfifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count[ADDR_WIDTH];
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_unit.sv
// Egress port: buffers whole packets from the crossbar and bursts each one downstream
// after a req/ack link grant, retrying the request when the ack times out.
module output_unit #(
    parameter int unsigned FLIT_SIZE   = router_pkg::FLIT_SIZE,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ACK_TIMEOUT = router_pkg::OU_ACK_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_switch_valid,
    input  logic [FLIT_SIZE-1:0] i_switch_flit,
    output logic                 o_switch_ready,
    output logic                 o_port_busy,
    output logic                 o_packet_sent,
    output logic                 o_downstream_req,
    input  logic                 i_downstream_ack,
    output logic [FLIT_SIZE-1:0] o_flit,
    output logic [1:0]           o_err
);
    import router_pkg::*;

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [FLIT_SIZE-1:0] ValidBit = {1'b1, {(FLIT_SIZE-1){1'b0}}};

    OU_STATE_t            state;
    logic [FLIT_SIZE-1:0] head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 push_tail;
    logic                 pop_tail;
    logic [AW:0]          tail_cnt;
    logic [CntW-1:0]      to_cnt;

    assign push      = i_switch_valid && !full && i_switch_flit[FLIT_SIZE-1];
    assign pop       = (state == OU_SEND) && !empty;
    assign push_tail = push && (FLIT_TYPE_t'(i_switch_flit[FLIT_SIZE-2 -: 2]) == TAIL_FLIT);
    assign pop_tail  = pop && (FLIT_TYPE_t'(head[FLIT_SIZE-2 -: 2]) == TAIL_FLIT);

    assign o_switch_ready   = !full;
    assign o_port_busy      = (state != OU_IDLE);
    assign o_downstream_req = (state inside {OU_REQ, OU_SEND});

    sfifo #(
        .DATA_WIDTH (FLIT_SIZE),
        .ADDR_WIDTH (AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (i_switch_flit),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

    // Number of complete packets sitting in the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tail_cnt <= '0;
        end else if (push_tail && !pop_tail) begin
            tail_cnt <= tail_cnt + 1'b1;
        end else if (pop_tail && !push_tail) begin
            tail_cnt <= tail_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= OU_IDLE;
            to_cnt        <= '0;
            o_flit        <= '0;
            o_packet_sent <= 1'b0;
            o_err         <= '0;
        end else begin
            o_packet_sent <= 1'b0;
            // A packet longer than the buffer can never complete: flag it and stay stuck.
            if (full && (tail_cnt == '0)) begin
                o_err[OU_ERR_OVERFLOW] <= 1'b1;
            end
            case (state)
                OU_IDLE: begin
                    if (tail_cnt != '0) begin
                        state  <= OU_REQ;
                        to_cnt <= '0;
                    end
                end
                OU_REQ: begin
                    if (i_downstream_ack) begin
                        state  <= OU_SEND;
                        to_cnt <= '0;
                    end else if (to_cnt == CntW'(ACK_TIMEOUT - 1)) begin
                        state                 <= OU_RETRY;
                        o_err[OU_ERR_TIMEOUT] <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                OU_RETRY: begin
                    to_cnt <= '0;
                    state  <= OU_REQ;
                end
                OU_SEND: begin
                    if (pop) begin
                        o_flit <= head | ValidBit;
                        if (pop_tail) begin
                            state         <= OU_DONE;
                            o_packet_sent <= 1'b1;
                        end
                    end
                end
                OU_DONE: begin
                    o_flit <= '0;
                    state  <= OU_IDLE;
                end
                default: state <= OU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_unit.sv
// Bench for output_unit: packet-level reference model compared every cycle, directed
// scenarios with hand-computed expectations, then randomized packet traffic.
module tb_output_unit;
    import router_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ACK_TO = 4;
    localparam int          W      = 16;
    localparam logic [W-1:0] MSB   = 16'h8000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         sw_valid = 1'b0;
    logic [W-1:0] sw_flit = '0;
    logic         ack = 1'b0;
    logic         ready, busy, sent, req;
    logic [W-1:0] oflit;
    logic [1:0]   err;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    bit rand_ack = 1'b0;

    output_unit #(
        .FLIT_SIZE   (W),
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_switch_valid   (sw_valid),
        .i_switch_flit    (sw_flit),
        .o_switch_ready   (ready),
        .o_port_busy      (busy),
        .o_packet_sent    (sent),
        .o_downstream_req (req),
        .i_downstream_ack (ack),
        .o_flit           (oflit),
        .o_err            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [1:0] t, input logic [12:0] d, input bit v);
        return {v, t, d};
    endfunction

    function automatic bit is_tail(input logic [W-1:0] f);
        return f[W-2 -: 2] == 2'(TAIL_FLIT);
    endfunction

    // Reference model: a queue of buffered flits plus the link phase of the port.
    logic [W-1:0] mq[$];
    bit           m_wait_link = 1'b0;
    bit           m_backoff = 1'b0;
    bit           m_stream = 1'b0;
    bit           m_finish = 1'b0;
    int           m_age = 0;
    logic [W-1:0] m_flit = '0;
    logic [1:0]   m_err = '0;

    always @(posedge clk or negedge reset_n) begin
        int tails;
        bit was_full;
        logic [W-1:0] h;
        if (!reset_n) begin
            mq.delete();
            m_wait_link = 1'b0;
            m_backoff = 1'b0;
            m_stream = 1'b0;
            m_finish = 1'b0;
            m_age = 0;
            m_flit = '0;
            m_err = '0;
        end else begin
            tails = 0;
            foreach (mq[i]) if (is_tail(mq[i])) tails++;
            was_full = (mq.size() == DEPTH);
            if (m_finish) begin
                m_finish = 1'b0;
                m_flit = '0;
            end else if (m_stream) begin
                if (mq.size() > 0) begin
                    h = mq.pop_front();
                    m_flit = h | MSB;
                    if (is_tail(h)) begin
                        m_stream = 1'b0;
                        m_finish = 1'b1;
                    end
                end
            end else if (m_backoff) begin
                m_backoff = 1'b0;
                m_wait_link = 1'b1;
                m_age = 0;
            end else if (m_wait_link) begin
                m_age++;
                if (ack) begin
                    m_wait_link = 1'b0;
                    m_stream = 1'b1;
                end else if (m_age == ACK_TO) begin
                    m_wait_link = 1'b0;
                    m_backoff = 1'b1;
                    m_err[0] = 1'b1;
                end
            end else if (tails > 0) begin
                m_wait_link = 1'b1;
                m_age = 0;
            end
            if (was_full && tails == 0) m_err[1] = 1'b1;
            if (sw_valid && sw_flit[W-1] && !was_full) mq.push_back(sw_flit);
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            check("m_req", req, m_wait_link || m_stream);
            check("m_busy", busy, m_wait_link || m_backoff || m_stream || m_finish);
            check("m_sent", sent, m_finish);
            check("m_flit", oflit, m_flit);
            check("m_ready", ready, mq.size() < DEPTH);
            check("m_err", err, m_err);
        end
    end

    int sent_pulses = 0;
    int low_run = 0;
    int last_gap = 0;
    always @(negedge clk) begin
        if (sent) sent_pulses++;
        if (!req) low_run++;
        else begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        if (rand_ack) ack = ($urandom_range(0, 1) == 1);
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] f);
        int n = 0;
        while (!ready && n < 200) begin
            sw_valid = 1'b0;
            tick();
            n++;
        end
        if (!ready) check("ready_wait", ready, 1);
        sw_valid = 1'b1;
        sw_flit = f;
        tick();
    endtask

    task automatic wait_sent(input string name, input int limit);
        int n = 0;
        while (!sent && n < limit) begin
            tick();
            n++;
        end
        check(name, sent, 1);
    endtask

    task automatic do_reset();
        sw_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic         e_req[7];
    logic         e_sent[7];
    logic         e_busy[7];
    logic [W-1:0] e_flit[7];

    initial begin
        int n;
        int s0;
        int len;
        logic [1:0] t;

        repeat (2) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_flit", oflit, 0);
        check("rst_busy", busy, 0);
        check("rst_sent", sent, 0);
        check("rst_err", err, 0);
        check("rst_ready", ready, 1);
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Single 3-flit packet, ack always high.
        ack = 1'b1;
        send(16'h8011);
        send(16'hA022);
        send(16'hC033);
        sw_valid = 1'b0;
        e_req  = '{0, 1, 1, 1, 1, 0, 0};
        e_sent = '{0, 0, 0, 0, 0, 1, 0};
        e_flit = '{16'h0, 16'h0, 16'h0, 16'h8011, 16'hA022, 16'hC033, 16'h0};
        for (int i = 0; i < 7; i++) begin
            check("t1_req", req, e_req[i]);
            check("t1_flit", oflit, e_flit[i]);
            check("t1_sent", sent, e_sent[i]);
            tick();
        end
        repeat (2) tick();

        // Ack withheld: request, back off one cycle, request again.
        ack = 1'b0;
        send(16'hC044);
        sw_valid = 1'b0;
        e_req = '{0, 1, 1, 1, 1, 0, 1};
        for (int i = 0; i < 7; i++) begin
            check("t2_req", req, e_req[i]);
            tick();
        end
        check("t2_err", err, 2'b01);
        ack = 1'b1;
        wait_sent("t2_sent", 20);
        check("t2_flit", oflit, 16'hC044);
        repeat (3) tick();

        // Two back-to-back 2-flit packets.
        s0 = sent_pulses;
        send(16'h8055);
        send(16'hC056);
        send(16'h8057);
        send(16'hC058);
        sw_valid = 1'b0;
        repeat (15) tick();
        check("t3_pulses", sent_pulses - s0, 2);
        check("t3_gap", last_gap, 2);

        // Overflow: four body flits with no tail.
        do_reset();
        send(16'hA001);
        send(16'hA002);
        send(16'hA003);
        send(16'hA004);
        check("t4_ready", ready, 0);
        tick();
        check("t4_err", err, 2'b10);
        for (int i = 0; i < 8; i++) begin
            check("t4_req", req, 0);
            tick();
        end
        sw_valid = 1'b0;

        // Invalid (MSB=0) flits between head and tail are dropped.
        do_reset();
        send(16'h8061);
        send(16'h2062);
        send(16'h4063);
        send(16'hC064);
        sw_valid = 1'b0;
        e_flit = '{16'h0, 16'h0, 16'h0, 16'h8061, 16'hC064, 16'h0, 16'h0};
        e_sent = '{0, 0, 0, 0, 1, 0, 0};
        e_busy = '{0, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            check("t5_flit", oflit, e_flit[i]);
            check("t5_sent", sent, e_sent[i]);
            check("t5_busy", busy, e_busy[i]);
            tick();
        end

        // Reset while sending.
        send(16'h8071);
        send(16'hA072);
        send(16'hC073);
        sw_valid = 1'b0;
        n = 0;
        while (oflit != 16'h8071 && n < 20) begin
            tick();
            n++;
        end
        check("t6_head", oflit, 16'h8071);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_req", req, 0);
        check("t6_rst_flit", oflit, 0);
        check("t6_rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        check("t6_ready", ready, 1);
        send(16'h8081);
        send(16'hC082);
        sw_valid = 1'b0;
        wait_sent("t6_sent", 20);
        check("t6_tail", oflit, 16'hC082);

        // Randomized traffic with random ack and interleaved invalid flits.
        do_reset();
        rand_ack = 1'b1;
        for (int p = 0; p < 80; p++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                if (k == len - 1) t = 2'(TAIL_FLIT);
                else if (k == 0) t = 2'(HEAD_FLIT);
                else t = 2'(BODY_FLIT);
                if ($urandom_range(0, 3) == 0) send(mk(2'($urandom_range(0, 3)), 13'($urandom), 1'b0));
                if ($urandom_range(0, 2) == 0) begin
                    sw_valid = 1'b0;
                    tick();
                end
                send(mk(t, 13'($urandom), 1'b1));
            end
        end
        sw_valid = 1'b0;
        rand_ack = 1'b0;
        ack = 1'b1;
        n = 0;
        while ((busy || mq.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check("drain_busy", busy, 0);
        check("drain_ready", ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
